// File: rtl/hwce_job_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hwce_job_ctrl_pkg
//  Description : Shared constants, FSM state type and helpers for the
//                HWCE multi-context job controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package hwce_job_ctrl_pkg;

    // Byte offsets of the control window
    localparam logic [31:0] REG_TRIGGER    = 32'h0000_0000;
    localparam logic [31:0] REG_ACQUIRE    = 32'h0000_0004;
    localparam logic [31:0] REG_FINISHED   = 32'h0000_0008;
    localparam logic [31:0] REG_RUNNING_ID = 32'h0000_000C;
    localparam logic [31:0] REG_SOFT_CLEAR = 32'h0000_0010;
    localparam logic [31:0] REG_JOB_BASE   = 32'h0000_0040;

    localparam logic [31:0] ACQUIRE_FAIL   = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } state_e;

    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/hwce_job_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hwce_job_ctrl_if
//  Description : PERIPH INTC configuration target port bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hwce_job_ctrl_if #(
    parameter int CFG_ID_WIDTH = 16
);
    logic                    cfg_req_i;
    logic                    cfg_gnt_o;
    logic [31:0]             cfg_add_i;
    logic                    cfg_type_i;
    logic [3:0]              cfg_be_i;
    logic [31:0]             cfg_data_i;
    logic [CFG_ID_WIDTH-1:0] cfg_ID_i;
    logic                    cfg_r_valid_o;
    logic [31:0]             cfg_r_data_o;
    logic [CFG_ID_WIDTH-1:0] cfg_r_ID_o;

    modport master (
        output cfg_req_i, cfg_add_i, cfg_type_i, cfg_be_i, cfg_data_i, cfg_ID_i,
        input  cfg_gnt_o, cfg_r_valid_o, cfg_r_data_o, cfg_r_ID_o
    );

    modport slave (
        input  cfg_req_i, cfg_add_i, cfg_type_i, cfg_be_i, cfg_data_i, cfg_ID_i,
        output cfg_gnt_o, cfg_r_valid_o, cfg_r_data_o, cfg_r_ID_o
    );
endinterface
`default_nettype wire

// File: rtl/hwce_job_ctrl_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : hwce_job_regfile
//  Description : N_CONTEXT x N_REGS job register array, byte-masked write,
//                one config read port and a full-image engine read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module hwce_job_regfile
    import hwce_job_ctrl_pkg::*;
#(
    parameter int N_CONTEXT = 2,
    parameter int N_REGS    = 16,
    parameter int CTX_W     = 1,
    parameter int IDX_W     = 4
) (
    input  wire logic                  clk,
    input  wire logic                  i_we,
    input  wire logic [CTX_W-1:0]      i_wr_ctx,
    input  wire logic [IDX_W-1:0]      i_wr_idx,
    input  wire logic [3:0]            i_be,
    input  wire logic [31:0]           i_wdata,
    input  wire logic [CTX_W-1:0]      i_rd_ctx,
    input  wire logic [IDX_W-1:0]      i_rd_idx,
    output logic      [31:0]           o_rd_data,
    input  wire logic [CTX_W-1:0]      i_eng_ctx,
    output logic      [N_REGS*32-1:0]  o_eng_regs
);

    logic [31:0] r_mem [N_CONTEXT][N_REGS];
    logic [31:0] w_mask;

    assign w_mask = be_to_mask(i_be);

    // Contents are deliberately left unreset: software programs every job
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_ctx][i_wr_idx] <= (r_mem[i_wr_ctx][i_wr_idx] & ~w_mask)
                                       | (i_wdata & w_mask);
        end
    end

    assign o_rd_data = r_mem[i_rd_ctx][i_rd_idx];

    generate
        for (genvar g = 0; g < N_REGS; g++) begin : g_eng_regs
            assign o_eng_regs[32*g +: 32] = r_mem[i_eng_ctx][g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/hwce_job_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hwce_job_ctrl
//  Description : Multi-context job controller: config register file, in-order
//                job queue, job IDs and per-context completion events.
//  Revision    : 1.0 - initial release
// ============================================================================
module hwce_job_ctrl
    import hwce_job_ctrl_pkg::*;
#(
    parameter int N_CONTEXT      = 2,
    parameter int N_REGS         = 16,
    parameter int CFG_ADDR_WIDTH = 11,
    parameter int CFG_DATA_WIDTH = 32,
    parameter int CFG_ID_WIDTH   = 16,
    parameter int JOB_ID_WIDTH   = 8
) (
    input  wire logic                          clk,
    input  wire logic                          rst,
    hwce_job_ctrl_if.slave                     cfg,
    output logic                               eng_start_o,
    output logic                               eng_clear_o,
    output logic [$clog2(N_CONTEXT)-1:0]       eng_ctx_o,
    output logic [N_REGS*32-1:0]               eng_regs_o,
    input  wire logic                          eng_done_i,
    output logic [N_CONTEXT-1:0]               evt_o,
    output logic                               busy_o
);

    localparam int CTX_W = $clog2(N_CONTEXT);
    localparam int CNT_W = $clog2(N_CONTEXT + 1);
    localparam int IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    localparam int AW    = CFG_ADDR_WIDTH;

    localparam logic [AW-3:0]    c_W_TRIGGER  = REG_TRIGGER[AW-1:2];
    localparam logic [AW-3:0]    c_W_ACQUIRE  = REG_ACQUIRE[AW-1:2];
    localparam logic [AW-3:0]    c_W_FINISHED = REG_FINISHED[AW-1:2];
    localparam logic [AW-3:0]    c_W_RUN_ID   = REG_RUNNING_ID[AW-1:2];
    localparam logic [AW-3:0]    c_W_CLEAR    = REG_SOFT_CLEAR[AW-1:2];
    localparam logic [AW-3:0]    c_W_JOB_BASE = REG_JOB_BASE[AW-1:2];
    localparam logic [AW-3:0]    c_N_REGS     = (AW-2)'(N_REGS);
    localparam logic [CNT_W-1:0] c_FULL       = CNT_W'(N_CONTEXT);

    state_e                    r_state, w_state_nxt;
    logic [CTX_W-1:0]          r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]          r_count;
    logic                      r_lock;
    logic [JOB_ID_WIDTH-1:0]   r_job_id_cnt;
    logic [JOB_ID_WIDTH-1:0]   r_job_id [N_CONTEXT];
    logic [JOB_ID_WIDTH-1:0]   r_last_done_id;
    logic [N_CONTEXT-1:0]      r_evt;
    logic                      r_clear_pulse;
    logic                      r_rvalid;
    logic [CFG_DATA_WIDTH-1:0] r_rdata;
    logic [CFG_ID_WIDTH-1:0]   r_rid;

    logic [AW-3:0]             w_word, w_job_off;
    logic                      w_rd, w_wr, w_hit_job;
    logic                      w_acq_ok, w_acquire, w_commit, w_clear, w_reg_we;
    logic                      w_done, w_start, w_busy;
    logic [N_CONTEXT-1:0]      w_evt_vec;
    logic [31:0]               w_rf_rdata;
    logic [CFG_DATA_WIDTH-1:0] w_rdata;
    logic                      w_unused;

    // ------------------------------------------------------------------
    // Address decode and request qualification
    // ------------------------------------------------------------------
    assign w_word    = cfg.cfg_add_i[AW-1:2];
    assign w_job_off = w_word - c_W_JOB_BASE;
    assign w_hit_job = (w_word >= c_W_JOB_BASE) && (w_job_off < c_N_REGS);
    assign w_rd      = cfg.cfg_req_i &  cfg.cfg_type_i;
    assign w_wr      = cfg.cfg_req_i & ~cfg.cfg_type_i;
    assign w_acq_ok  = ~r_lock && (r_count < c_FULL);
    assign w_acquire = w_rd && (w_word == c_W_ACQUIRE) && w_acq_ok;
    assign w_commit  = w_wr && (w_word == c_W_TRIGGER) && r_lock;
    assign w_clear   = w_wr && (w_word == c_W_CLEAR);
    assign w_reg_we  = w_wr && w_hit_job && r_lock;
    assign w_unused  = ^{cfg.cfg_add_i[31:AW], cfg.cfg_add_i[1:0]};

    assign cfg.cfg_gnt_o = cfg.cfg_req_i;

    hwce_job_regfile #(
        .N_CONTEXT (N_CONTEXT),
        .N_REGS    (N_REGS),
        .CTX_W     (CTX_W),
        .IDX_W     (IDX_W)
    ) u_regfile (
        .clk        (clk),
        .i_we       (w_reg_we),
        .i_wr_ctx   (r_wr_ptr),
        .i_wr_idx   (w_job_off[IDX_W-1:0]),
        .i_be       (cfg.cfg_be_i),
        .i_wdata    (cfg.cfg_data_i),
        .i_rd_ctx   (r_wr_ptr),
        .i_rd_idx   (w_job_off[IDX_W-1:0]),
        .o_rd_data  (w_rf_rdata),
        .i_eng_ctx  (r_rd_ptr),
        .o_eng_regs (eng_regs_o)
    );

    // ------------------------------------------------------------------
    // Engine FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (r_count != '0) w_state_nxt = START;
            START:   w_state_nxt = RUN;
            RUN:     if (eng_done_i) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (w_clear) begin
            w_state_nxt = IDLE;
        end
    end

    always_comb begin
        w_start   = (r_state == START);
        w_done    = (r_state == RUN) && eng_done_i;
        w_busy    = (r_count != '0) || (r_state != IDLE);
        w_evt_vec = N_CONTEXT'(1) << r_rd_ptr;
    end

    // ------------------------------------------------------------------
    // Queue pointers, lock and completion bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_lock         <= 1'b0;
            r_last_done_id <= '0;
        end else if (w_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_lock   <= 1'b0;
        end else begin
            if (w_acquire) begin
                r_lock <= 1'b1;
            end else if (w_commit) begin
                r_lock   <= 1'b0;
                r_wr_ptr <= r_wr_ptr + CTX_W'(1);
            end
            if (w_done) begin
                r_rd_ptr       <= r_rd_ptr + CTX_W'(1);
                r_last_done_id <= r_job_id[r_rd_ptr];
            end
            // Simultaneous commit and completion leave the occupancy unchanged
            case ({w_commit, w_done})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Job IDs survive a soft clear so software sees a continuing sequence
    always_ff @(posedge clk) begin
        if (rst) begin
            r_job_id_cnt <= '0;
            for (int i = 0; i < N_CONTEXT; i++) begin
                r_job_id[i] <= '0;
            end
        end else if (w_acquire) begin
            r_job_id[r_wr_ptr] <= r_job_id_cnt;
            r_job_id_cnt       <= r_job_id_cnt + JOB_ID_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_evt         <= '0;
            r_clear_pulse <= 1'b0;
        end else begin
            r_evt         <= (w_done && !w_clear) ? w_evt_vec : '0;
            r_clear_pulse <= w_clear;
        end
    end

    // ------------------------------------------------------------------
    // Read data and response channel
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        if (w_rd) begin
            if (w_word == c_W_ACQUIRE) begin
                w_rdata = w_acq_ok ? CFG_DATA_WIDTH'(r_job_id_cnt) : ACQUIRE_FAIL;
            end else if (w_word == c_W_FINISHED) begin
                w_rdata = {(r_state == RUN), 7'b0, 8'(r_count), 8'b0, 8'(r_last_done_id)};
            end else if (w_word == c_W_RUN_ID) begin
                w_rdata = CFG_DATA_WIDTH'(r_job_id[r_rd_ptr]);
            end else if (w_hit_job) begin
                w_rdata = w_rf_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rid    <= '0;
        end else begin
            r_rvalid <= cfg.cfg_req_i;
            r_rdata  <= w_rdata;
            r_rid    <= cfg.cfg_ID_i;
        end
    end

    assign cfg.cfg_r_valid_o = r_rvalid;
    assign cfg.cfg_r_data_o  = r_rdata;
    assign cfg.cfg_r_ID_o    = r_rid;

    assign eng_start_o = w_start;
    assign eng_clear_o = r_clear_pulse;
    assign eng_ctx_o   = r_rd_ptr;
    assign evt_o       = r_evt;
    assign busy_o      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_hwce_job_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hwce_job_ctrl
//  Description : Directed self-checking bench for hwce_job_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hwce_job_ctrl;
    import hwce_job_ctrl_pkg::*;

    localparam int N_CONTEXT = 2;
    localparam int N_REGS    = 16;
    localparam int IDW       = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  eng_start, eng_clear, eng_done, busy;
    logic [0:0]            eng_ctx;
    logic [N_REGS*32-1:0]  eng_regs;
    logic [N_CONTEXT-1:0]  evt;

    int                    n_checks = 0;
    int                    n_fail   = 0;
    logic [IDW-1:0]        id_seq   = 16'h0100;

    always #5 clk = ~clk;

    hwce_job_ctrl_if #(.CFG_ID_WIDTH(IDW)) cfg_if ();

    hwce_job_ctrl #(
        .N_CONTEXT      (N_CONTEXT),
        .N_REGS         (N_REGS),
        .CFG_ADDR_WIDTH (11),
        .CFG_DATA_WIDTH (32),
        .CFG_ID_WIDTH   (IDW),
        .JOB_ID_WIDTH   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg         (cfg_if),
        .eng_start_o (eng_start),
        .eng_clear_o (eng_clear),
        .eng_ctx_o   (eng_ctx),
        .eng_regs_o  (eng_regs),
        .eng_done_i  (eng_done),
        .evt_o       (evt),
        .busy_o      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request cycle; response checked just after the following edge
    task automatic cfg_xfer(input string tag, input logic rd, input logic [31:0] addr,
                            input logic [3:0] be, input logic [31:0] wdata,
                            input logic [31:0] exp);
        logic [IDW-1:0] id;
        id = id_seq;
        id_seq++;
        cfg_if.cfg_req_i  = 1'b1;
        cfg_if.cfg_type_i = rd;
        cfg_if.cfg_add_i  = addr;
        cfg_if.cfg_be_i   = be;
        cfg_if.cfg_data_i = wdata;
        cfg_if.cfg_ID_i   = id;
        #1;
        chk({tag, ".gnt"}, 32'(cfg_if.cfg_gnt_o), 32'd1);
        @(posedge clk);
        #1;
        cfg_if.cfg_req_i  = 1'b0;
        chk({tag, ".valid"}, 32'(cfg_if.cfg_r_valid_o), 32'd1);
        chk({tag, ".id"},    32'(cfg_if.cfg_r_ID_o),    32'(id));
        chk({tag, ".data"},  cfg_if.cfg_r_data_o,       exp);
    endtask

    initial begin
        rst               = 1'b1;
        eng_done          = 1'b0;
        cfg_if.cfg_req_i  = 1'b0;
        cfg_if.cfg_type_i = 1'b0;
        cfg_if.cfg_add_i  = '0;
        cfg_if.cfg_be_i   = '0;
        cfg_if.cfg_data_i = '0;
        cfg_if.cfg_ID_i   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst.start", 32'(eng_start), 32'd0);
        chk("rst.clear", 32'(eng_clear), 32'd0);
        chk("rst.evt",   32'(evt),       32'd0);
        chk("rst.busy",  32'(busy),      32'd0);
        chk("rst.valid", 32'(cfg_if.cfg_r_valid_o), 32'd0);

        // First ACQUIRE locks, second one is refused
        cfg_xfer("acq0", 1'b1, REG_ACQUIRE, 4'hF, 32'h0, 32'h0000_0000);
        cfg_xfer("acq0b", 1'b1, REG_ACQUIRE, 4'hF, 32'h0, 32'hFFFF_FFFF);
        tick();
        chk("valid.drop", 32'(cfg_if.cfg_r_valid_o), 32'd0);

        // Byte-masked job register write, then launch
        cfg_xfer("wr40z", 1'b0, 32'h40, 4'hF,    32'h0,         32'h0);
        cfg_xfer("wr40",  1'b0, 32'h40, 4'b0011, 32'hDEAD_BEEF, 32'h0);
        cfg_xfer("rd40",  1'b1, 32'h40, 4'hF,    32'h0,         32'h0000_BEEF);
        cfg_xfer("trig0", 1'b0, REG_TRIGGER, 4'hF, 32'h0, 32'h0);
        chk("trig0.nostart", 32'(eng_start), 32'd0);
        tick();
        chk("job0.start", 32'(eng_start), 32'd1);
        chk("job0.ctx",   32'(eng_ctx),   32'd0);
        chk("job0.reg0",  eng_regs[31:0], 32'h0000_BEEF);
        chk("job0.busy",  32'(busy),      32'd1);
        tick();
        chk("job0.run", 32'(eng_start), 32'd0);

        // Fill the queue while job 0 runs
        cfg_xfer("acq1",  1'b1, REG_ACQUIRE, 4'hF, 32'h0, 32'h0000_0001);
        cfg_xfer("wr44a", 1'b0, 32'h44, 4'hF, 32'hA5A5_0001, 32'h0);
        cfg_xfer("trig1", 1'b0, REG_TRIGGER, 4'hF, 32'h0, 32'h0);
        cfg_xfer("acqful", 1'b1, REG_ACQUIRE, 4'hF, 32'h0, 32'hFFFF_FFFF);
        cfg_xfer("fin.full", 1'b1, REG_FINISHED, 4'hF, 32'h0, 32'h8002_0000);
        cfg_xfer("runid0", 1'b1, REG_RUNNING_ID, 4'hF, 32'h0, 32'h0);

        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        chk("done0.evt", 32'(evt), 32'h1);
        cfg_xfer("acq2wrap", 1'b1, REG_ACQUIRE, 4'hF, 32'h0, 32'h0000_0002);
        chk("job1.start", 32'(eng_start), 32'd1);
        chk("job1.ctx",   32'(eng_ctx),   32'd1);
        chk("job1.reg1",  eng_regs[63:32], 32'hA5A5_0001);

        // Protection: writes and triggers without the lock are ignored
        cfg_xfer("wr44b", 1'b0, 32'h44, 4'hF, 32'h1234_5678, 32'h0);
        cfg_xfer("trig2", 1'b0, REG_TRIGGER, 4'hF, 32'h0, 32'h0);
        cfg_xfer("wr44nl", 1'b0, 32'h44, 4'hF, 32'hCAFE_F00D, 32'h0);
        cfg_xfer("rd44nl", 1'b1, 32'h44, 4'hF, 32'h0, 32'hA5A5_0001);

        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        chk("done1.evt", 32'(evt), 32'h2);
        tick();
        chk("job2.start", 32'(eng_start), 32'd1);
        chk("job2.ctx",   32'(eng_ctx),   32'd0);
        chk("job2.reg1",  eng_regs[63:32], 32'h1234_5678);

        // Commit and completion in the same cycle
        cfg_xfer("acq3", 1'b1, REG_ACQUIRE, 4'hF, 32'h0, 32'h0000_0003);
        eng_done = 1'b1;
        cfg_xfer("trig3", 1'b0, REG_TRIGGER, 4'hF, 32'h0, 32'h0);
        eng_done = 1'b0;
        chk("done2.evt", 32'(evt), 32'h1);
        cfg_xfer("fin.same", 1'b1, REG_FINISHED, 4'hF, 32'h0, 32'h0001_0002);
        chk("job3.start", 32'(eng_start), 32'd1);
        chk("job3.ctx",   32'(eng_ctx),   32'd1);
        tick();

        // Soft clear wins over a coincident completion
        eng_done = 1'b1;
        cfg_xfer("clr0", 1'b0, REG_SOFT_CLEAR, 4'hF, 32'h0, 32'h0);
        eng_done = 1'b0;
        chk("clr0.pulse", 32'(eng_clear), 32'd1);
        chk("clr0.evt",   32'(evt),       32'd0);
        chk("clr0.busy",  32'(busy),      32'd0);
        cfg_xfer("acq4", 1'b1, REG_ACQUIRE, 4'hF, 32'h0, 32'h0000_0004);
        chk("clr0.drop", 32'(eng_clear), 32'd0);

        cfg_xfer("clr1",   1'b0, REG_SOFT_CLEAR, 4'hF, 32'h0, 32'h0);
        cfg_xfer("runid4", 1'b1, REG_RUNNING_ID, 4'hF, 32'h0, 32'h0000_0004);
        cfg_xfer("trignl", 1'b0, REG_TRIGGER, 4'hF, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("trignl.nostart", 32'(eng_start), 32'd0);
            chk("trignl.busy",    32'(busy),      32'd0);
            tick();
        end

        // Reset while a job runs
        cfg_xfer("acq5",  1'b1, REG_ACQUIRE, 4'hF, 32'h0, 32'h0000_0005);
        cfg_xfer("trig5", 1'b0, REG_TRIGGER, 4'hF, 32'h0, 32'h0);
        tick();
        tick();
        chk("job5.busy", 32'(busy), 32'd1);
        rst      = 1'b1;
        eng_done = 1'b1;
        tick();
        rst      = 1'b0;
        eng_done = 1'b0;
        chk("rstjob.evt",   32'(evt),       32'd0);
        chk("rstjob.busy",  32'(busy),      32'd0);
        chk("rstjob.start", 32'(eng_start), 32'd0);
        cfg_xfer("acq.rst", 1'b1, REG_ACQUIRE, 4'hF, 32'h0, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
